// File: rtl/conv_stream_feeder.sv
// Host-side front end for the convolver: buffers one X and one F vector from a
// load port, then streams both out on independent valid/ready channels.
module conv_stream_feeder #(
  parameter int WIDTH = 8,
  parameter int X_LEN = 8,
  parameter int F_LEN = 4,
  parameter int XLOG  = 3,
  parameter int FLOG  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic             load_sel,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] m_data_out_x,
  output logic             m_valid_x,
  input  logic             m_ready_x,
  output logic [WIDTH-1:0] m_data_out_f,
  output logic             m_valid_f,
  input  logic             m_ready_f
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_xbuf [X_LEN];
  logic [WIDTH-1:0] r_fbuf [F_LEN];

  logic [XLOG-1:0]  r_xptr;
  logic [FLOG-1:0]  r_fptr;
  logic             r_xfull;
  logic             r_ffull;
  logic [XLOG-1:0]  r_xidx;
  logic [FLOG-1:0]  r_fidx;
  logic             r_xvalid;
  logic             r_fvalid;
  logic [WIDTH-1:0] r_xdata;
  logic [WIDTH-1:0] r_fdata;
  logic             r_load_ready;
  logic             r_busy;
  logic             r_done;

  logic             w_load_x;
  logic             w_load_f;
  logic             w_start;
  logic             w_xfer_x;
  logic             w_xfer_f;
  logic             w_xlast;
  logic             w_flast;
  logic             w_xvalid_nxt;
  logic             w_fvalid_nxt;
  logic [WIDTH-1:0] w_x0;
  logic [WIDTH-1:0] w_f0;

  // r_load_ready is only high in IDLE, so it doubles as the IDLE qualifier for loads.
  assign w_load_x = load_valid && r_load_ready && !load_sel;
  assign w_load_f = load_valid && r_load_ready &&  load_sel;
  // Full flags are the pre-write values, so a same-cycle load cannot enable start.
  assign w_start  = (r_state == ST_IDLE) && start && r_xfull && r_ffull;
  assign w_xfer_x = r_xvalid && m_ready_x;
  assign w_xfer_f = r_fvalid && m_ready_f;
  assign w_xlast  = (r_xidx == XLOG'(X_LEN - 1));
  assign w_flast  = (r_fidx == FLOG'(F_LEN - 1));

  // Forward a same-cycle overwrite of element 0 into the first streamed word.
  assign w_x0 = (w_load_x && (r_xptr == {XLOG{1'b0}})) ? load_data : r_xbuf[0];
  assign w_f0 = (w_load_f && (r_fptr == {FLOG{1'b0}})) ? load_data : r_fbuf[0];

  // Next-cycle valid for each stream channel.
  always_comb begin
    w_xvalid_nxt = r_xvalid;
    w_fvalid_nxt = r_fvalid;
    if (w_start) begin
      w_xvalid_nxt = 1'b1;
      w_fvalid_nxt = 1'b1;
    end else begin
      if (w_xfer_x && w_xlast) begin
        w_xvalid_nxt = 1'b0;
      end else begin
        w_xvalid_nxt = r_xvalid;
      end
      if (w_xfer_f && w_flast) begin
        w_fvalid_nxt = 1'b0;
      end else begin
        w_fvalid_nxt = r_fvalid;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_STREAM;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (!w_xvalid_nxt && !w_fvalid_nxt) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_STREAM;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_load_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_load_ready <= (w_state_nxt == ST_IDLE);
      r_busy       <= (w_state_nxt == ST_STREAM);
      r_done       <= (w_state_nxt == ST_DONE);
    end
  end

  // Load pointers and full flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_xptr  <= {XLOG{1'b0}};
      r_fptr  <= {FLOG{1'b0}};
      r_xfull <= 1'b0;
      r_ffull <= 1'b0;
    end else begin
      if (w_load_x) begin
        if (r_xptr == XLOG'(X_LEN - 1)) begin
          r_xptr  <= {XLOG{1'b0}};
          r_xfull <= 1'b1;
        end else begin
          r_xptr <= r_xptr + XLOG'(1);
        end
      end
      if (w_load_f) begin
        if (r_fptr == FLOG'(F_LEN - 1)) begin
          r_fptr  <= {FLOG{1'b0}};
          r_ffull <= 1'b1;
        end else begin
          r_fptr <= r_fptr + FLOG'(1);
        end
      end
    end
  end

  // Vector storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_load_x) begin
      r_xbuf[r_xptr] <= load_data;
    end
    if (w_load_f) begin
      r_fbuf[r_fptr] <= load_data;
    end
  end

  // Stream channel registers: index, presented word and valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_xidx   <= {XLOG{1'b0}};
      r_fidx   <= {FLOG{1'b0}};
      r_xdata  <= {WIDTH{1'b0}};
      r_fdata  <= {WIDTH{1'b0}};
      r_xvalid <= 1'b0;
      r_fvalid <= 1'b0;
    end else begin
      r_xvalid <= w_xvalid_nxt;
      r_fvalid <= w_fvalid_nxt;
      if (w_start) begin
        r_xidx  <= {XLOG{1'b0}};
        r_xdata <= w_x0;
        r_fidx  <= {FLOG{1'b0}};
        r_fdata <= w_f0;
      end else begin
        if (w_xfer_x && !w_xlast) begin
          r_xidx  <= r_xidx + XLOG'(1);
          r_xdata <= r_xbuf[r_xidx + XLOG'(1)];
        end
        if (w_xfer_f && !w_flast) begin
          r_fidx  <= r_fidx + FLOG'(1);
          r_fdata <= r_fbuf[r_fidx + FLOG'(1)];
        end
      end
    end
  end

  assign load_ready   = r_load_ready;
  assign busy         = r_busy;
  assign done         = r_done;
  assign m_data_out_x = r_xdata;
  assign m_valid_x    = r_xvalid;
  assign m_data_out_f = r_fdata;
  assign m_valid_f    = r_fvalid;

endmodule

// File: doc/conv_stream_feeder.md
Name: conv_stream_feeder

Overview:
- Transmit side of the conv_8_4 input interface. Buffers one X vector (X_LEN samples) and one F vector (F_LEN taps) written over a simple load port.
- On start, streams both vectors out on two independent valid/ready channels that connect directly to the convolver's s_*_x / s_*_f inputs.
- Used as the stimulus and host-side front end for the convolution datapath.

Parameters:
- WIDTH, 8, sample/tap width in bits (signed, passed through unmodified)
- X_LEN, 8, number of X samples per vector
- F_LEN, 4, number of F taps per vector
- XLOG, 3, index width for X (clog2 X_LEN)
- FLOG, 2, index width for F (clog2 F_LEN)

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- load_valid  in  1  load word present
- load_sel  in  1  0 = word targets X buffer, 1 = F buffer
- load_data  in  WIDTH  load word
- load_ready  out  1  feeder accepts load words
- start  in  1  request one streaming pass
- busy  out  1  streaming pass in progress
- done  out  1  one-cycle pulse: pass complete
- m_data_out_x  out  WIDTH  X stream data
- m_valid_x  out  1  X stream valid
- m_ready_x  in  1  X stream ready from convolver
- m_data_out_f  out  WIDTH  F stream data
- m_valid_f  out  1  F stream valid
- m_ready_f  in  1  F stream ready from convolver

Behaviour:
- Reset (reset = 0, asynchronous assert): all outputs are 0 and the state is IDLE. Load pointers, stream indices and full flags are 0. Buffer contents are don't-care. Deassertion is taken synchronously at the next clk edge.
- States:
  - IDLE: loading allowed. load_ready = 1, busy = 0.
  - STREAM: load_ready = 0, busy = 1.
  - DONE: lasts one cycle, done = 1, then returns to IDLE.
- Load (IDLE only):
  - A word is written when load_valid && load_ready. It goes to buf[load_sel][ptr_sel], and ptr_sel increments.
  - Each pointer wraps to 0 after its last index and sets that vector's full flag. The flag stays set until reset.
  - Further loads after wrap overwrite from index 0.
  - A word offered outside IDLE is not written (load_ready = 0).
- Start:
  - Sampled only in IDLE with both full flags set. The next cycle the state is STREAM, with m_valid_x = 1, m_data_out_x = x[0], m_valid_f = 1, m_data_out_f = f[0].
  - Start in IDLE without both full flags set is ignored: no state change, no error.
  - Start outside IDLE is ignored.
  - If load_valid and start occur in the same IDLE cycle, the load is performed and start is evaluated against the full flags from before that write.
- Stream channels (X and F are independent; rules are written for X, and F is identical with F_LEN):
  - A transfer occurs on a cycle where m_valid_x && m_ready_x.
  - While m_valid_x = 1 && m_ready_x = 0, m_data_out_x and m_valid_x hold stable.
  - After transferring index i < X_LEN-1, the next cycle presents x[i+1] with m_valid_x still 1. There are no bubbles, so throughput is 1 word per cycle.
  - After transferring index X_LEN-1, m_valid_x = 0 next cycle and the X channel is finished.
  - m_ready_x is ignored while m_valid_x = 0.
- Completion: when both channels are finished (in either order, or on the same cycle), the next state is DONE. busy falls when DONE is entered. done pulses for exactly one cycle, then IDLE.
- Repeat: buffers and full flags persist, so a new start replays the same vectors from index 0.
- Data passes bit-exact; there is no sign extension or arithmetic.
- Reset mid-stream aborts the pass immediately: valids, busy and done go to 0 and full flags are cleared.

Test Plan:
- Load X = 1..8 and F = 2,0,-1,3, start, hold m_ready_x = m_ready_f = 1 -> X emits 1..8 on 8 consecutive cycles, F emits 2,0,-1,3 on 4 consecutive cycles; busy stays 1 until the X channel finishes; done pulses one cycle later.
- Same vectors, m_ready_x toggling 1,0,1,0 -> each X word held stable during every ready = 0 cycle; exactly 8 transfers, order preserved; total 15 cycles from first valid to last transfer.
- Start after loading only 5 X words and all 4 F words -> no valid asserted, busy = 0; load 3 more X words, then start -> normal stream.
- During STREAM assert load_valid with load_data = 0x55 -> load_ready = 0; after done, replay shows original X/F contents unchanged.
- Pull reset low at the 3rd X transfer -> all outputs 0 asynchronously; after release, start is ignored until both vectors are reloaded.
- Back-to-back: start on the cycle after done -> second pass identical to the first; buffers retained.
